// File: rtl/uart_frame_parser_pkg.sv
// Shared types and constants for the UART frame parser: FSM states, error
// codes, sync header bytes and the length-acceptance helper.
`timescale 1ns/1ps
package uart_frame_parser_pkg;

   localparam int unsigned BYTE_W = 8;

   localparam logic [BYTE_W-1:0] SYNC0 = 8'h55;
   localparam logic [BYTE_W-1:0] SYNC1 = 8'hAA;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HDR2    = 3'd1,
      ST_LEN     = 3'd2,
      ST_PAYLOAD = 3'd3,
      ST_CHK     = 3'd4,
      ST_OUT     = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      ERR_OVERRUN = 2'b00,
      ERR_BAD_LEN = 2'b01,
      ERR_BAD_CHK = 2'b10,
      ERR_TIMEOUT = 2'b11
   } err_e;

   // A length byte is usable when non-zero and within the buffer depth.
   function automatic logic len_ok(input logic [BYTE_W-1:0] len, input int unsigned max_len);
      return (len != 8'd0) && (32'(len) <= max_len);
   endfunction

endpackage

// File: rtl/uart_frame_parser_if.sv
// Byte-in / payload-out bundle of the frame parser, with frame status pulses.
`timescale 1ns/1ps
interface uart_frame_parser_if;
   import uart_frame_parser_pkg::*;

   logic [BYTE_W-1:0] rx_data;
   logic              rx_valid;
   logic [BYTE_W-1:0] pl_data;
   logic              pl_valid;
   logic              pl_ready;
   logic              pl_last;
   logic              frame_ok;
   logic              frame_err;
   logic [1:0]        err_code;

   modport master (
      output rx_data, rx_valid, pl_ready,
      input  pl_data, pl_valid, pl_last, frame_ok, frame_err, err_code
   );

   modport slave (
      input  rx_data, rx_valid, pl_ready,
      output pl_data, pl_valid, pl_last, frame_ok, frame_err, err_code
   );
endinterface

// File: rtl/uart_frame_buf.sv
// Payload store: one synchronous write port, one asynchronous read port.
`timescale 1ns/1ps
module uart_frame_buf #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/uart_frame_parser.sv
// Parses 55 AA LEN payload CHK frames from a UART byte stream, buffers the
// payload and streams it out once the checksum has been verified.
`timescale 1ns/1ps
module uart_frame_parser
   import uart_frame_parser_pkg::*;
#(
   parameter int unsigned CLK_FRE     = 50_000_000,
   parameter int unsigned BAUD        = 9600,
   parameter int unsigned MAX_LEN     = 16,
   parameter int unsigned TIMEOUT_CYC = CLK_FRE / BAUD * 20
) (
   input  logic         clk,
   input  logic         rst,
   uart_frame_parser_if.slave bus
);

   localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

   state_e              state, state_nxt;
   logic [BYTE_W-1:0]   len, sum, wr_idx, rd_idx;
   logic [TW-1:0]       to_cnt;
   logic                frame_ok, frame_err;
   err_e                err_code;
   logic [BYTE_W-1:0]   rd_data;

   logic                active_c, timeout_c, len_bad_c, wr_last_c, rd_last_c;
   logic                ok_set_c, err_set_c, buf_we_c, len_take_c;
   err_e                err_nxt_c;
   logic                pl_valid_c, pl_last_c;
   logic [BYTE_W-1:0]   pl_data_c;

   // Frame-level conditions shared by next-state and output logic.
   assign active_c  = (state == ST_HDR2) || (state == ST_LEN) ||
                      (state == ST_PAYLOAD) || (state == ST_CHK);
   assign timeout_c = active_c && (to_cnt == TW'(TIMEOUT_CYC - 1));
   assign len_bad_c = !len_ok(bus.rx_data, MAX_LEN);
   assign wr_last_c = (wr_idx == len - 8'd1);
   assign rd_last_c = (rd_idx == len - 8'd1);

   uart_frame_buf #(
      .DEPTH (MAX_LEN),
      .AW    (AW)
   ) u_buf (
      .clk   (clk),
      .we    (buf_we_c),
      .waddr (AW'(wr_idx)),
      .wdata (bus.rx_data),
      .raddr (AW'(rd_idx)),
      .rdata (rd_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Timeout outranks any byte arriving in the same cycle.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: begin
            if (bus.rx_valid && bus.rx_data == SYNC0) state_nxt = ST_HDR2;
         end
         ST_HDR2: begin
            if (timeout_c)                              state_nxt = ST_IDLE;
            else if (bus.rx_valid && bus.rx_data == SYNC1) state_nxt = ST_LEN;
            else if (bus.rx_valid && bus.rx_data != SYNC0) state_nxt = ST_IDLE;
         end
         ST_LEN: begin
            if (timeout_c)          state_nxt = ST_IDLE;
            else if (bus.rx_valid)  state_nxt = len_bad_c ? ST_IDLE : ST_PAYLOAD;
         end
         ST_PAYLOAD: begin
            if (timeout_c)                      state_nxt = ST_IDLE;
            else if (bus.rx_valid && wr_last_c) state_nxt = ST_CHK;
         end
         ST_CHK: begin
            if (timeout_c)          state_nxt = ST_IDLE;
            else if (bus.rx_valid)  state_nxt = (bus.rx_data == sum) ? ST_OUT : ST_IDLE;
         end
         ST_OUT: begin
            if (bus.pl_ready && rd_last_c) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      ok_set_c   = 1'b0;
      err_set_c  = 1'b0;
      err_nxt_c  = err_code;
      buf_we_c   = 1'b0;
      len_take_c = 1'b0;
      pl_valid_c = 1'b0;
      pl_last_c  = 1'b0;
      pl_data_c  = 8'h00;
      if (timeout_c) begin
         err_set_c = 1'b1;
         err_nxt_c = ERR_TIMEOUT;
      end else begin
         unique case (state)
            ST_LEN: begin
               if (bus.rx_valid && len_bad_c) begin
                  err_set_c = 1'b1;
                  err_nxt_c = ERR_BAD_LEN;
               end else if (bus.rx_valid) begin
                  len_take_c = 1'b1;
               end
            end
            ST_PAYLOAD: buf_we_c = bus.rx_valid;
            ST_CHK: begin
               if (bus.rx_valid && bus.rx_data == sum) begin
                  ok_set_c = 1'b1;
               end else if (bus.rx_valid) begin
                  err_set_c = 1'b1;
                  err_nxt_c = ERR_BAD_CHK;
               end
            end
            ST_OUT: begin
               pl_valid_c = 1'b1;
               pl_last_c  = rd_last_c;
               pl_data_c  = rd_data;
               if (bus.rx_valid) begin
                  err_set_c = 1'b1;
                  err_nxt_c = ERR_OVERRUN;
               end
            end
            default: ;
         endcase
      end
   end

   // Status pulses, frame length, running checksum and buffer indices.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         err_code  <= ERR_OVERRUN;
         len       <= 8'h00;
         sum       <= 8'h00;
         wr_idx    <= 8'h00;
         rd_idx    <= 8'h00;
         to_cnt    <= '0;
      end else begin
         frame_ok  <= ok_set_c;
         frame_err <= err_set_c;
         err_code  <= err_nxt_c;
         if (!active_c || timeout_c || bus.rx_valid) to_cnt <= '0;
         else                                        to_cnt <= to_cnt + TW'(1);
         if (len_take_c) begin
            len    <= bus.rx_data;
            sum    <= bus.rx_data;
            wr_idx <= 8'h00;
         end
         if (buf_we_c) begin
            sum    <= sum + bus.rx_data;
            wr_idx <= wr_idx + 8'd1;
         end
         if (pl_valid_c && bus.pl_ready) rd_idx <= rd_last_c ? 8'h00 : rd_idx + 8'd1;
      end
   end

   assign bus.pl_valid  = pl_valid_c;
   assign bus.pl_last   = pl_last_c;
   assign bus.pl_data   = pl_data_c;
   assign bus.frame_ok  = frame_ok;
   assign bus.frame_err = frame_err;
   assign bus.err_code  = err_code;

endmodule
